// File: rtl/usb_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : usb_rx_pkg                                                       |
// | Brief    : Shared state encoding and constants for the USB RX control path |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package usb_rx_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SYNC_RCV = 3'd1,
        SYNC_CHK = 3'd2,
        RECEIVE  = 3'd3,
        WRITE    = 3'd4,
        EOP_WAIT = 3'd5,
        ERR_WAIT = 3'd6,
        EIDLE    = 3'd7
    } state_t;

    localparam logic [7:0] USB_SYNC_BYTE = 8'h80;
    localparam int         BITS_PER_BYTE = 8;

endpackage
`default_nettype wire

// File: rtl/usb_rx_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : usb_rx_ctrl                                                      |
// | Brief    : USB RX control FSM: SYNC check, FIFO writes, framing/overflow   |
// |            errors. USB_RX_PKT_LEN_EN adds pkt_len/pkt_done reporting.      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module usb_rx_ctrl
    import usb_rx_pkg::*;
#(
    parameter logic [7:0] SYNC_PATTERN = USB_SYNC_BYTE,
    parameter int         MAX_BYTES    = 64,
    parameter int         BYTE_CNT_W   = $clog2(MAX_BYTES + 1)
)(
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  d_edge,
    input  logic                  eop,
    input  logic                  shift_enable,
    input  logic                  byte_received,
    input  logic [7:0]            rcv_data,
    output logic                  timer_en,
    output logic                  timer_clr,
    output logic                  rcving,
    output logic                  w_enable,
    output logic                  r_error
`ifdef USB_RX_PKT_LEN_EN
    ,
    output logic [BYTE_CNT_W-1:0] pkt_len,
    output logic                  pkt_done
`endif
);

    localparam int                    C_BIT_CNT_W = $clog2(BITS_PER_BYTE);
    localparam logic [BYTE_CNT_W-1:0] C_MAX_BYTES = BYTE_CNT_W'(MAX_BYTES);

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [C_BIT_CNT_W-1:0]  r_bit_cnt;
    logic [BYTE_CNT_W-1:0]   r_byte_cnt;
    logic                    r_eop_seen;
    logic                    w_timer_en_nxt;
    logic                    w_timer_clr_nxt;
    logic                    w_rcving_nxt;
    logic                    w_enable_nxt;
    logic                    w_error_nxt;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:     if (d_edge) w_state_nxt = SYNC_RCV;
            SYNC_RCV: begin
                if (byte_received)  w_state_nxt = SYNC_CHK;
                else if (eop)       w_state_nxt = ERR_WAIT;
            end
            SYNC_CHK: w_state_nxt = (rcv_data == SYNC_PATTERN) ? RECEIVE : ERR_WAIT;
            RECEIVE: begin
                // A completed byte beats a simultaneous EOP; EOP is re-seen on return.
                if (byte_received)  w_state_nxt = WRITE;
                else if (eop)       w_state_nxt = (r_bit_cnt == '0) ? EOP_WAIT : ERR_WAIT;
            end
            WRITE:    w_state_nxt = (r_byte_cnt == C_MAX_BYTES) ? ERR_WAIT : RECEIVE;
            EOP_WAIT: if (!eop) w_state_nxt = IDLE;
            ERR_WAIT: if (r_eop_seen && !eop) w_state_nxt = EIDLE;
            EIDLE:    if (d_edge) w_state_nxt = SYNC_RCV;
            default:  w_state_nxt = IDLE;
        endcase

        w_timer_en_nxt  = w_state_nxt inside {SYNC_RCV, SYNC_CHK, RECEIVE, WRITE};
        w_rcving_nxt    = !(w_state_nxt inside {IDLE, EIDLE});
        w_error_nxt     = w_state_nxt inside {ERR_WAIT, EIDLE};
        w_timer_clr_nxt = (r_state inside {IDLE, EIDLE}) && (w_state_nxt == SYNC_RCV);
        // The write strobe is suppressed up front when this byte would overflow.
        w_enable_nxt    = (r_state == RECEIVE) && (w_state_nxt == WRITE) &&
                          (r_byte_cnt != C_MAX_BYTES);
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state   <= IDLE;
            timer_en  <= 1'b0;
            timer_clr <= 1'b0;
            rcving    <= 1'b0;
            w_enable  <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            timer_en  <= w_timer_en_nxt;
            timer_clr <= w_timer_clr_nxt;
            rcving    <= w_rcving_nxt;
            w_enable  <= w_enable_nxt;
            r_error   <= w_error_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
            r_eop_seen <= 1'b0;
        end else begin
            if (byte_received || timer_clr)
                r_bit_cnt <= '0;
            else if (shift_enable && timer_en)
                r_bit_cnt <= r_bit_cnt + C_BIT_CNT_W'(1);

            if ((r_state == SYNC_CHK) && (w_state_nxt == RECEIVE))
                r_byte_cnt <= '0;
            else if ((r_state == WRITE) && (r_byte_cnt != C_MAX_BYTES))
                r_byte_cnt <= r_byte_cnt + BYTE_CNT_W'(1);

            // Recovery needs a full EOP assert/deassert seen while in ERR_WAIT.
            if (w_state_nxt == ERR_WAIT) begin
                if (eop) r_eop_seen <= 1'b1;
            end else begin
                r_eop_seen <= 1'b0;
            end
        end
    end

`ifdef USB_RX_PKT_LEN_EN
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            pkt_len  <= '0;
            pkt_done <= 1'b0;
        end else begin
            pkt_done <= (r_state == EOP_WAIT) && (w_state_nxt == IDLE);
            if ((r_state == EOP_WAIT) && (w_state_nxt == IDLE))
                pkt_len <= r_byte_cnt;
        end
    end
`endif

endmodule
`default_nettype wire

// File: doc/usb_rx_ctrl.md
Name: usb_rx_ctrl

Overview:
- Receive control FSM for the USB RX datapath. It sequences the bit/byte timer: clears it, enables its counting, and consumes its shift_enable and byte_count strobes.
- Qualifies the SYNC byte, writes each received data byte to the RX FIFO, and flags framing and overflow errors.
- Sits between the edge detector / EOP decoder and the timer plus shift register, upstream of the RX FIFO and AHB-side status logic.

Parameters:
- SYNC_PATTERN, 8'h80, expected post-decode SYNC byte as presented on rcv_data.
- MAX_BYTES, 64, maximum data bytes per packet after SYNC; must be ≥1.
- BYTE_CNT_W, $clog2(MAX_BYTES+1), width of the internal byte counter.

Ports:
- clk  in  1  system clock
- n_rst  in  1  synchronous active-low reset
- d_edge  in  1  1-cycle pulse: transition detected on the decoded data line
- eop  in  1  level: end-of-packet (SE0) currently present
- shift_enable  in  1  1-cycle pulse from timer: one bit sampled
- byte_received  in  1  1-cycle pulse from timer: 8 bits sampled (timer byte_count)
- rcv_data  in  8  shift register contents, valid in the cycle after byte_received
- timer_en  out  1  timer count enable (drives the timer's sync_byte)
- timer_clr  out  1  1-cycle timer clear
- rcving  out  1  packet in progress
- w_enable  out  1  1-cycle FIFO write strobe; data = rcv_data
- r_error  out  1  sticky receive error

Behaviour:
- Reset: clk is the only clock; reset is synchronous, active-low on n_rst.
  - While n_rst=0 at a clk edge: state=IDLE, bit_cnt=0, byte_cnt=0, all outputs 0.
  - Reset mid-packet aborts with no FIFO write.
- All outputs are registered (Moore) and change one cycle after the causing input.
- bit_cnt (3-bit):
  - Increments on shift_enable while timer_en=1.
  - Cleared on byte_received and on timer_clr.
  - byte_received takes priority if it coincides with shift_enable.
- IDLE: timer_en=0, rcving=0.
  - d_edge → SYNC_RCV. The transition cycle registers timer_clr=1 for exactly one cycle and clears r_error.
  - eop is ignored in IDLE.
- SYNC_RCV: timer_en=1, rcving=1.
  - byte_received → SYNC_CHK.
  - eop → ERR_WAIT.
- SYNC_CHK (1 cycle): timer_en=1.
  - rcv_data==SYNC_PATTERN → RECEIVE, with byte_cnt cleared.
  - Otherwise → ERR_WAIT.
- RECEIVE: timer_en=1, rcving=1.
  - byte_received → WRITE.
  - eop with bit_cnt==0 → EOP_WAIT (normal end).
  - eop with bit_cnt!=0 → ERR_WAIT (partial byte).
  - If eop and byte_received coincide, byte_received wins: → WRITE; eop is re-evaluated in RECEIVE.
- WRITE (1 cycle): w_enable=1, byte_cnt+1.
  - If the pre-increment byte_cnt==MAX_BYTES → ERR_WAIT with no write (overflow).
  - Otherwise → RECEIVE.
- EOP_WAIT: timer_en=0, rcving=1. When eop deasserts → IDLE.
- ERR_WAIT: r_error=1, timer_en=0, rcving=1.
  - Waits for eop assert, then deassert → EIDLE.
  - w_enable never asserts in this state.
- EIDLE: r_error=1, rcving=0.
  - d_edge → SYNC_RCV with timer_clr, which clears r_error.
- Width rules:
  - byte_cnt saturates; it cannot wrap because overflow is caught in WRITE.
  - The bit_cnt wrap from 7 to 0 only occurs via byte_received.

Optional Feature:
- Macro: USB_RX_PKT_LEN_EN.
- Defined:
  - Adds output pkt_len[BYTE_CNT_W-1:0] and 1-bit pkt_done.
  - On the EOP_WAIT→IDLE transition, pkt_len loads byte_cnt and pkt_done pulses for 1 cycle.
  - pkt_len holds its value otherwise; reset value 0.
  - Error packets never update pkt_len.
- Undefined: the ports and registers do not exist. All other behaviour is identical.

Decomposition:
- Package usb_rx_pkg:
  - state_t enum: IDLE, SYNC_RCV, SYNC_CHK, RECEIVE, WRITE, EOP_WAIT, ERR_WAIT, EIDLE.
  - USB_SYNC_BYTE constant 8'h80.
  - BITS_PER_BYTE constant 8.
- Sub-module: none new. bit_cnt may be an instance of the existing flex_counter (NUM_CNT_BITS=4, rollover 8). The FSM stays in usb_rx_ctrl.

Test Plan:
- Good packet:
  - Stimulus: d_edge, SYNC 8'h80, data 8'hA5, 8'h3C, eop at bit_cnt=0.
  - Expect: exactly 2 w_enable pulses carrying A5 then 3C, r_error=0, rcving low 1 cycle after eop deasserts.
  - With USB_RX_PKT_LEN_EN: pkt_len=2, pkt_done 1 pulse.
- Bad SYNC:
  - Stimulus: first byte 8'h81.
  - Expect: SYNC_CHK→ERR_WAIT, r_error=1, no w_enable; after eop cycle, d_edge clears r_error and a good packet then passes.
- Partial byte:
  - Stimulus: 1 data byte, 3 shift_enable pulses, then eop.
  - Expect: 1 w_enable, r_error=1, timer_en=0 next cycle.
- Overflow (MAX_BYTES=4):
  - Stimulus: 5 data bytes.
  - Expect: 4 w_enable pulses, 5th byte not written, r_error=1.
- Coincidence:
  - Stimulus: byte_received and eop in the same cycle.
  - Expect: byte written (w_enable), then normal EOP_WAIT, no error.
- Reset mid-packet:
  - Stimulus: n_rst=0 for 1 cycle during RECEIVE.
  - Expect: at the next edge all outputs 0, state IDLE; subsequent eop ignored, no w_enable.
